rr_lock_arb: RTL



---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 35 +++
 rtl/rr_lock_arb.sv | 107 ++++++++++
 3 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiters.
// Holds the lock-arbiter state encoding and a width helper.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bits needed to index v items; never returns 0 so it
    // is always usable as a vector width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set req bit above last, wrapping.
// Ports: req (vector), last (index) -> valid, pick (index).
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ = 8,
    parameter int IW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last,
    output logic               valid,
    output logic [IW-1:0]      pick
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest
    // candidate after last is the one that sticks.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = int'(last) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                valid = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arb.sv
// Round-robin lock arbiter with hold-limit revocation.
// Ports: clk, rst, i_req, i_release -> o_grant, o_owner, o_busy, o_timeout.
module rr_lock_arb
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_release,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [clog2(NUM_REQ)-1:0] o_owner,
    output logic                      o_busy,
    output logic                      o_timeout
);

    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);
    localparam logic [CW-1:0] CNT_LIM  = CW'(MAX_HOLD - 1);

    state_t               state, state_d;
    logic [CW-1:0]        hold_cnt, cnt_d;
    logic [IW-1:0]        last_owner, last_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic [IW-1:0]        owner_d;
    logic                 busy_d;
    logic                 timeout_d;

    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic                 rel_hit;
    logic                 wd_hit;
    logic                 lim_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (i_req),
        .last  (last_owner),
        .valid (pick_vld),
        .pick  (pick_idx)
    );

    assign rel_hit = i_release[o_owner];
    assign wd_hit  = ~i_req[o_owner];
    assign lim_hit = (hold_cnt == CNT_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_owner <= LAST_RST;
            o_grant    <= '0;
            o_owner    <= '0;
            o_busy     <= 1'b0;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_d;
            hold_cnt   <= cnt_d;
            last_owner <= last_d;
            o_grant    <= grant_d;
            o_owner    <= owner_d;
            o_busy     <= busy_d;
            o_timeout  <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = hold_cnt;
        last_d    = last_owner;
        grant_d   = o_grant;
        owner_d   = o_owner;
        busy_d    = o_busy;
        timeout_d = 1'b0;
        unique case (state)
            IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                if (pick_vld) begin
                    state_d = GRANT;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            GRANT: begin
                cnt_d = hold_cnt + CW'(1);
                if (rel_hit || wd_hit || lim_hit) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    // A voluntary exit in the same cycle
                    // masks the revocation pulse.
                    timeout_d = lim_hit & ~rel_hit & ~wd_hit;
                end
            end
        endcase
    end

endmodule
